// File: rtl/pattern_sequencer_if.sv
// Handshake bundle for pattern_sequencer: control inputs, pattern load and registered outputs.
// The master side drives the requests and the slave (the sequencer) drives the pattern state.
interface pattern_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
);
  logic             srst;
  logic             go_left;
  logic             go_right;
  logic [1:0]       mode;
  logic [DIV_W-1:0] rate;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] seq_out;
  logic             dir;
  logic             tick;

  modport master (
    output srst, go_left, go_right, mode, rate, load, load_val,
    input  seq_out, dir, tick
  );

  modport slave (
    input  srst, go_left, go_right, mode, rate, load, load_val,
    output seq_out, dir, tick
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Rotating / bouncing bit-pattern sequencer with manual stepping, a programmable auto-step
// prescaler, synchronous restart and pattern load. All outputs come straight from registers.
module pattern_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input logic              clk,
  input logic              rst,
  pattern_sequencer_if.slave bus
);

  localparam logic [1:0]       MODE_MAN  = 2'b00;
  localparam logic [1:0]       MODE_ROT  = 2'b01;
  localparam logic [1:0]       MODE_BNC  = 2'b10;
  localparam logic [1:0]       MODE_HOLD = 2'b11;
  localparam logic [WIDTH-1:0] RESET_PAT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] seq_r, seq_s;
  logic             dir_r, dir_s;
  logic [DIV_W-1:0] cnt_r, cnt_s;
  logic             tick_r, tick_s;
  logic [1:0]       mode_r;
  logic             mode_vld_r;
  logic             eff_dir_s;
  logic             step_s;
  logic             mode_chg_s;

  // Next-state selection: srst beats load, load beats the per-mode action.
  always_comb begin
    seq_s      = seq_r;
    dir_s      = dir_r;
    cnt_s      = cnt_r;
    tick_s     = 1'b0;
    step_s     = (cnt_r >= bus.rate);
    // mode_vld_r masks the first cycle after rst, so a stale mode_r cannot steal a step
    mode_chg_s = mode_vld_r && (bus.mode != mode_r);
    if (bus.go_left) begin
      eff_dir_s = 1'b1;
    end else if (bus.go_right) begin
      eff_dir_s = 1'b0;
    end else begin
      eff_dir_s = dir_r;
    end

    if (bus.srst) begin
      seq_s = RESET_PAT;
      dir_s = 1'b0;
      cnt_s = CNT_ZERO;
    end else if (bus.load) begin
      seq_s = bus.load_val;
      cnt_s = CNT_ZERO;
    end else if (mode_chg_s) begin
      cnt_s = CNT_ZERO;
    end else begin
      case (bus.mode)
        MODE_MAN: begin
          cnt_s = CNT_ZERO;
          if (bus.go_left) begin
            seq_s = rot_left(seq_r);
            dir_s = 1'b1;
          end else if (bus.go_right) begin
            seq_s = rot_right(seq_r);
            dir_s = 1'b0;
          end else begin
            seq_s = seq_r;
          end
        end
        MODE_ROT: begin
          dir_s = eff_dir_s;
          if (step_s) begin
            seq_s  = eff_dir_s ? rot_left(seq_r) : rot_right(seq_r);
            cnt_s  = CNT_ZERO;
            tick_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        MODE_BNC: begin
          if (step_s) begin
            cnt_s  = CNT_ZERO;
            tick_s = 1'b1;
            // Reversal only when the lit end bit is on the side we are heading to
            if (eff_dir_s && seq_r[WIDTH-1]) begin
              dir_s = 1'b0;
              seq_s = rot_right(seq_r);
            end else if (!eff_dir_s && seq_r[0]) begin
              dir_s = 1'b1;
              seq_s = rot_left(seq_r);
            end else begin
              dir_s = eff_dir_s;
              seq_s = eff_dir_s ? rot_left(seq_r) : rot_right(seq_r);
            end
          end else begin
            dir_s = eff_dir_s;
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        MODE_HOLD: begin
          seq_s = seq_r;
        end
        default: begin
          seq_s = seq_r;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_r      <= RESET_PAT;
      dir_r      <= 1'b0;
      cnt_r      <= CNT_ZERO;
      tick_r     <= 1'b0;
      mode_r     <= MODE_MAN;
      mode_vld_r <= 1'b0;
    end else begin
      seq_r      <= seq_s;
      dir_r      <= dir_s;
      cnt_r      <= cnt_s;
      tick_r     <= tick_s;
      mode_r     <= bus.mode;
      mode_vld_r <= 1'b1;
    end
  end

  assign bus.seq_out = seq_r;
  assign bus.dir     = dir_r;
  assign bus.tick    = tick_r;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the pattern width in bits (legal range 2..32).
REQ-002 Parameter DIV_W, default 24, SHALL set the auto-step prescaler width in bits.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 srst  input  1  SHALL be the synchronous restart: pattern, direction and prescaler back to reset values.
REQ-006 go_left  input  1  SHALL be the manual step-left request in MAN mode, and the set-direction-left request in auto modes.
REQ-007 go_right  input  1  SHALL be the manual step-right request in MAN mode, and the set-direction-right request in auto modes.
REQ-008 mode  input  2  SHALL select the mode: 00 MAN, 01 ROT (auto rotate), 10 BNC (auto bounce), 11 HOLD.
REQ-009 rate  input  DIV_W  SHALL set the auto step period; the period is rate+1 clocks.
REQ-010 load  input  1  SHALL be the synchronous request to load load_val into the pattern.
REQ-011 load_val  input  WIDTH  SHALL be the pattern value captured on load.
REQ-012 seq_out  output  WIDTH  SHALL be the registered current pattern.
REQ-013 dir  output  1  SHALL be the registered direction: 1 = left (toward MSB), 0 = right.
REQ-014 tick  output  1  SHALL be a registered one-cycle pulse, high in the first cycle a new auto-stepped seq_out value is visible.

Function
REQ-015 Per-cycle priority SHALL be: srst, then load, then mode action.
REQ-016 srst SHALL set seq_out = 1<<(WIDTH-1), dir = 0, cnt = 0 and tick = 0 at the next edge.
REQ-017 load SHALL set seq_out = load_val at the next edge; dir SHALL be unchanged, cnt SHALL clear, and tick SHALL be 0.
REQ-018 Rotate-left SHALL be {seq_out[WIDTH-2:0], seq_out[WIDTH-1]}; rotate-right SHALL be {seq_out[0], seq_out[WIDTH-1:1]}.
REQ-019 MAN mode: go_left SHALL rotate left once per clock while high; go_right SHALL rotate right once per clock; go_left SHALL win when both are high; dir SHALL follow the last executed step; tick SHALL stay 0; cnt SHALL hold 0.
REQ-020 Prescaler, ROT/BNC modes: when cnt == rate the step SHALL execute and cnt SHALL become 0; otherwise cnt SHALL increment by 1; rate = 0 SHALL step every clock.
REQ-021 If rate is lowered below the current cnt, the next edge SHALL execute the step and clear cnt (compare is cnt >= rate).
REQ-022 Any change of mode SHALL clear cnt at the next edge, with no step in that cycle.
REQ-023 ROT mode: on step, rotate in dir; go_left/go_right SHALL only update dir (go_left wins), taking effect on the same-cycle step.
REQ-024 BNC mode: on step, if dir = 1 and seq_out[WIDTH-1] = 1, dir SHALL become 0 and the pattern SHALL rotate right in the same step; if dir = 0 and seq_out[0] = 1, dir SHALL become 1 and the pattern SHALL rotate left; otherwise it SHALL rotate in dir.
REQ-025 In BNC, go_left/go_right SHALL override dir as in ROT mode before the edge check is applied.
REQ-026 HOLD mode: seq_out, dir and cnt SHALL hold; go_left/go_right SHALL be ignored; tick SHALL be 0.
REQ-027 An all-zero pattern SHALL remain all-zero under every step; in BNC no reversal SHALL occur.
REQ-028 Multi-bit patterns SHALL be rotated intact with no bit loss.

Reset
REQ-029 Asserting rst SHALL immediately force seq_out = 1<<(WIDTH-1), dir = 0, cnt = 0 and tick = 0, regardless of clk, including mid-count and mid-bounce.
REQ-030 After rst deasserts, the first step in ROT/BNC SHALL occur rate+1 clocks later.

Verification
REQ-031 WIDTH=8, MAN, go_left high for 3 clocks from reset -> seq_out 01, 02, 04; dir = 1.
REQ-032 WIDTH=8, ROT, rate=2, dir=0 -> seq_out 80 -> 40 -> 20, stepping every 3 clocks, with tick high one cycle per step.
REQ-033 WIDTH=8, BNC, rate=0, load_val=02, dir=1 -> seq_out 04, 08, 10, 20, 40, 80, 40 with dir dropping to 0 on the 80->40 step.
REQ-034 Same cycle srst=1, load=1, go_left=1 -> seq_out = 80, dir = 0.
REQ-035 ROT, rate=5, rst pulsed at cnt=3 -> seq_out = 80 asynchronously; the next step occurs 6 clocks after release.
REQ-036 WIDTH=16, load_val=0000, BNC, 20 clocks -> seq_out = 0000 throughout, with dir constant.
